// File: rtl/sdf_r2_stage_pkg.sv
// rtl/sdf_r2_stage_pkg.sv - shared FFT constants, complex sample type and per-stage delay helper
package sdf_r2_stage_pkg;

    localparam int FFT_N  = 64;
    localparam int FFT_DW = 18;

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;

    // Delay-line depth of SDF stage s in an FFT_N-point pipeline.
    function automatic int stage_delay(input int stage);
        return FFT_N >> (stage + 1);
    endfunction

endpackage

// File: rtl/Butterfly.sv
// rtl/Butterfly.sv - radix-2 complex butterfly, wrap-around arithmetic, outputs zero when disabled
module Butterfly #(
    parameter int DATA_WIDTH = 18
) (
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] in1_r,
    input  logic signed [DATA_WIDTH-1:0] in1_i,
    input  logic signed [DATA_WIDTH-1:0] in2_r,
    input  logic signed [DATA_WIDTH-1:0] in2_i,
    output logic signed [DATA_WIDTH-1:0] sum_r,
    output logic signed [DATA_WIDTH-1:0] sum_i,
    output logic signed [DATA_WIDTH-1:0] diff_r,
    output logic signed [DATA_WIDTH-1:0] diff_i
);

    always_comb begin
        sum_r  = '0;
        sum_i  = '0;
        diff_r = '0;
        diff_i = '0;
        if (en) begin
            sum_r  = in1_r + in2_r;
            sum_i  = in1_i + in2_i;
            diff_r = in1_r - in2_r;
            diff_i = in1_i - in2_i;
        end
    end

endmodule

// File: rtl/sdf_r2_stage_delay_line.sv
// rtl/sdf_r2_stage_delay_line.sv - DELAY-deep circular buffer; head is the word written DELAY writes ago
module sdf_delay_line #(
    parameter int DELAY = 32,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DELAY > 1) ? $clog2(DELAY) : 1;

    logic [WIDTH-1:0] mem_q [DELAY];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (wr_en) begin
            ptr_d = (ptr_q == PTR_W'(DELAY - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage is deliberately unreset; the stage's primed gating hides stale words.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[ptr_q] <= wr_data;
        end
    end

    assign head = mem_q[ptr_q];

endmodule

// File: rtl/sdf_r2_stage.sv
// rtl/sdf_r2_stage.sv - radix-2 single-path delay-feedback FFT stage with per-sample output index
module sdf_r2_stage
    import sdf_r2_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int DELAY      = stage_delay(0),
    parameter int CNT_W      = (DELAY > 1) ? $clog2(2 * DELAY) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_r,
    input  logic signed [DATA_WIDTH-1:0] in_i,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_r,
    output logic signed [DATA_WIDTH-1:0] out_i,
    output logic [CNT_W-1:0]             out_idx
);

    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         primed_q, primed_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [DATA_WIDTH-1:0] out_r_q, out_r_d;
    logic signed [DATA_WIDTH-1:0] out_i_q, out_i_d;
    logic [CNT_W-1:0]             out_idx_q, out_idx_d;

    logic                         phase_b;
    logic                         bf_en;
    logic [2*DATA_WIDTH-1:0]      head;
    logic [2*DATA_WIDTH-1:0]      wr_data;
    logic signed [DATA_WIDTH-1:0] head_r, head_i;
    logic signed [DATA_WIDTH-1:0] sum_r, sum_i, diff_r, diff_i;

    // 2*DELAY is a power of two, so the counter MSB is exactly the phase-B decode.
    assign phase_b = cnt_q[CNT_W-1];
    assign bf_en   = in_valid & phase_b;
    assign head_r  = head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign head_i  = head[DATA_WIDTH-1:0];
    assign wr_data = phase_b ? {diff_r, diff_i} : {in_r, in_i};

    sdf_delay_line #(
        .DELAY (DELAY),
        .WIDTH (2 * DATA_WIDTH)
    ) u_delay_line (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (wr_data),
        .head    (head)
    );

    Butterfly #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_butterfly (
        .en     (bf_en),
        .in1_r  (head_r),
        .in1_i  (head_i),
        .in2_r  (in_r),
        .in2_i  (in_i),
        .sum_r  (sum_r),
        .sum_i  (sum_i),
        .diff_r (diff_r),
        .diff_i (diff_i)
    );

    always_comb begin
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        out_valid_d = in_valid & (phase_b | primed_q);
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;
        out_idx_d   = out_idx_q;
        if (in_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (&cnt_q) begin
                primed_d = 1'b1;
            end
        end
        // Only valid outputs load the register, so stale delay-line words never appear.
        if (out_valid_d) begin
            if (phase_b) begin
                out_r_d   = sum_r;
                out_i_d   = sum_i;
                out_idx_d = cnt_q - CNT_W'(DELAY);
            end else begin
                out_r_d   = head_r;
                out_i_d   = head_i;
                out_idx_d = cnt_q + CNT_W'(DELAY);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
            out_idx_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_i     = out_i_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_sdf_r2_stage.sv
// tb/tb_sdf_r2_stage.sv - directed-vector bench for sdf_r2_stage with DELAY=2
module tb_sdf_r2_stage;

    localparam int DW    = 18;
    localparam int DELAY = 2;
    localparam int CW    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic signed [DW-1:0] in_r, in_i;
    logic                 out_valid;
    logic signed [DW-1:0] out_r, out_i;
    logic [CW-1:0]        out_idx;

    int total = 0;
    int bad   = 0;

    int q_r[$], q_i[$], q_idx[$];
    int e_r[$], e_i[$], e_idx[$];

    always #5 clk = ~clk;

    sdf_r2_stage #(
        .DATA_WIDTH (DW),
        .DELAY      (DELAY),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_idx   (out_idx)
    );

    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1) begin
            q_r.push_back(int'(out_r));
            q_i.push_back(int'(out_i));
            q_idx.push_back(int'(out_idx));
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int r, input int i);
        @(negedge clk);
        in_valid = 1'b1;
        in_r     = DW'(r);
        in_i     = DW'(i);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_r     = '0;
            in_i     = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_valid", out_valid, 0);
            chk("rst_r", out_r, 0);
            chk("rst_i", out_i, 0);
            chk("rst_idx", out_idx, 0);
        end
        rst = 1'b1;
        q_r.delete(); q_i.delete(); q_idx.delete();
        e_r.delete(); e_i.delete(); e_idx.delete();
    endtask

    task automatic expect_out(input int r, input int i, input int idx);
        e_r.push_back(r);
        e_i.push_back(i);
        e_idx.push_back(idx);
    endtask

    task automatic compare_out(input string tag);
        int n;
        chk({tag, "_count"}, q_r.size(), e_r.size());
        n = (q_r.size() < e_r.size()) ? q_r.size() : e_r.size();
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_r%0d", tag, k), q_r[k], e_r[k]);
            chk($sformatf("%s_i%0d", tag, k), q_i[k], e_i[k]);
            chk($sformatf("%s_idx%0d", tag, k), q_idx[k], e_idx[k]);
        end
    endtask

    task automatic expect_basic();
        expect_out(4, 0, 0);
        expect_out(6, 0, 1);
        expect_out(-2, 0, 2);
        expect_out(-2, 0, 3);
    endtask

    task automatic drive_stalled(input int r);
        logic signed [DW-1:0] hr;
        logic [CW-1:0]        hidx;
        drive(r, 0);
        @(negedge clk);
        in_valid = 1'b0;
        hr   = out_r;
        hidx = out_idx;
        repeat (2) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 0);
            chk("stall_hold_r", out_r, hr);
            chk("stall_hold_idx", out_idx, hidx);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_r     = '0;
        in_i     = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid", out_valid, 0);
        chk("reset_r", out_r, 0);
        chk("reset_idx", out_idx, 0);
        rst = 1'b1;

        do_reset();
        drive(1, 0);
        drive(2, 0);
        @(negedge clk);
        chk("unprimed_no_valid", q_r.size(), 0);
        in_r = 3; in_i = 0;
        drive(4, 0);
        drive(0, 0); drive(0, 0);
        idle(2);
        expect_basic();
        compare_out("basic");

        do_reset();
        for (int k = 1; k <= 8; k++) drive(k, 0);
        drive(0, 0); drive(0, 0);
        idle(2);
        expect_out(4, 0, 0);  expect_out(6, 0, 1);
        expect_out(-2, 0, 2); expect_out(-2, 0, 3);
        expect_out(12, 0, 0); expect_out(14, 0, 1);
        expect_out(-2, 0, 2); expect_out(-2, 0, 3);
        compare_out("b2b");

        do_reset();
        drive_stalled(1); drive_stalled(2); drive_stalled(3);
        drive_stalled(4); drive_stalled(0); drive_stalled(0);
        expect_basic();
        compare_out("stall");

        do_reset();
        drive(131071, 0); drive(0, 0); drive(1, 0); drive(0, 0);
        drive(0, 0); drive(0, 0);
        idle(2);
        expect_out(-131072, 0, 0);
        expect_out(0, 0, 1);
        expect_out(131070, 0, 2);
        expect_out(0, 0, 3);
        compare_out("wrap");

        do_reset();
        drive(1, 2); drive(0, 0); drive(3, -1); drive(0, 0);
        drive(0, 0); drive(0, 0);
        idle(2);
        expect_out(4, 1, 0);
        expect_out(0, 0, 1);
        expect_out(-2, 3, 2);
        expect_out(0, 0, 3);
        compare_out("cplx");

        do_reset();
        drive(1, 0); drive(2, 0); drive(3, 0);
        do_reset();
        drive(1, 0); drive(2, 0); drive(3, 0); drive(4, 0);
        drive(0, 0); drive(0, 0);
        idle(2);
        expect_basic();
        compare_out("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
